// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
// The optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef logic [1:0] loaderState_t;

    localparam loaderState_t IDLE  = 2'd0;
    localparam loaderState_t LOAD  = 2'd1;
    localparam loaderState_t CHECK = 2'd2;
    localparam loaderState_t DONE  = 2'd3;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write, asynchronous (zero-latency) read.
// Contents are intentionally not reset.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction RAM while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] Read_Address,
    output logic [DATA_W-1:0] Instruction,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              chk_err
);

    loaderState_t      state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   lenCount;
    logic              lastByte;
    logic              wrEn;
    logic              startLoad;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loaderState_t AFTER_LOAD = CHECK;
`else
    localparam loaderState_t AFTER_LOAD = DONE;
`endif

    // A length of zero means a full memory image.
    assign lenCount  = (load_len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                        : {1'b0, load_len};
    assign lastByte  = (cnt == (ADDR_W+1)'(1));
    assign startLoad = (state == IDLE) && load_start;
    assign wrEn      = (state == LOAD) && in_valid;

    assign in_ready  = (state == LOAD) || (state == CHECK);
    assign busy      = (state != IDLE);
    assign cpu_hold  = busy;
    assign load_done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= LOAD;
                        ptr   <= '0;
                        cnt   <= lenCount;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        cnt <= cnt - (ADDR_W+1)'(1);
                        if (lastByte) begin
                            state <= AFTER_LOAD;
                        end
                    end
                end
                CHECK: begin
                    if (in_valid) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic              chkErrQ;

    // Error flag stays set until the next accepted load request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            chkErrQ <= 1'b0;
        end else if (startLoad) begin
            acc     <= '0;
            chkErrQ <= 1'b0;
        end else if (wrEn) begin
            acc <= acc ^ in_data;
        end else if ((state == CHECK) && in_valid) begin
            chkErrQ <= (in_data != acc);
        end
    end

    assign chk_err = chkErrQ;
`else
    assign chk_err = 1'b0;
`endif

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uRam (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (ptr),
        .wrData (in_data),
        .rdAddr (Read_Address),
        .rdData (Instruction)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed table plus random loads.
// Checks the checksum stage when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS_EN = 1;
`else
    localparam int CS_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic [7:0] load_len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [7:0] Read_Address = '0;
    logic [7:0] Instruction;
    logic       cpu_hold;
    logic       busy;
    logic       load_done;
    logic       chk_err;

    int errors = 0;
    int checks = 0;

    // Reference: what each address should hold, and whether it was written.
    logic [7:0] refMem [256];
    bit         refValid [256];
    logic [7:0] dataQ [$];
    bit         expChk = 1'b0;

    typedef struct {
        int          len;
        int          gap;
        logic [31:0] bytes;
        logic [7:0]  cs;
        bit          expErr;
    } vecT;

    vecT vecs [4];

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_len     (load_len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .Read_Address (Read_Address),
        .Instruction  (Instruction),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .load_done    (load_done),
        .chk_err      (chk_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chkIdle(string name);
        chk({name, "_rdy"}, in_ready, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_hold"}, cpu_hold, 0);
        chk({name, "_done"}, load_done, 0);
    endtask

    task automatic memCheck();
        for (int a = 0; a < 256; a++) begin
            Read_Address = a[7:0];
            #1;
            if (refValid[a]) chk("mem", Instruction, refMem[a]);
        end
    endtask

    task automatic idleNoise(int k);
        for (int i = 0; i < k; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            chkIdle("idle");
            step();
        end
        in_valid = 1'b0;
    endtask

    // Load n bytes from dataQ (plus checksum cs when built); gap<0 = random.
    task automatic runLoad(int n, int gap, logic [7:0] cs);
        int sent = 0;
        int total = n + CS_EN;
        int budget = total * 5 + 20;
        logic [7:0] x = '0;
        load_len   = n[7:0];
        load_start = 1'b1;
        in_valid   = 1'b0;
        step();
        load_start = 1'b0;
        expChk     = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rdy", in_ready, 1);
        chk("start_chkerr", chk_err, 0);
        while (sent < total && budget > 0) begin
            int g;
            logic [7:0] b;
            logic [7:0] addr;
            g = (gap < 0) ? $urandom_range(0, 3) : ((sent == 0) ? 0 : gap);
            for (int k = 0; k < g; k++) begin
                in_valid   = 1'b0;
                in_data    = 8'($urandom);
                load_start = ($urandom_range(0, 3) == 0);
                load_len   = 8'($urandom);
                #1;
                chk("gap_rdy", in_ready, 1);
                chk("gap_busy", busy, 1);
                chk("gap_done", load_done, 0);
                step();
                budget--;
            end
            addr       = sent[7:0];
            b          = (sent < n) ? dataQ[sent] : cs;
            in_valid   = 1'b1;
            in_data    = b;
            load_start = ($urandom_range(0, 3) == 0);
            load_len   = 8'($urandom);
            Read_Address = addr;
            #1;
            chk("xfer_rdy", in_ready, 1);
            chk("xfer_hold", cpu_hold, 1);
            chk("xfer_done", load_done, 0);
            if (sent < n && refValid[addr])
                chk("old_data", Instruction, refMem[addr]);
            step();
            budget--;
            if (sent < n) begin
                refMem[addr]   = b;
                refValid[addr] = 1'b1;
                x = x ^ b;
                chk("new_data", Instruction, b);
            end else begin
                expChk = (b != x);
            end
            sent++;
        end
        chk("load_count", sent, total);
        load_start = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'($urandom);
        #1;
        chk("done_pulse", load_done, 1);
        chk("done_busy", busy, 1);
        chk("done_rdy", in_ready, 0);
        step();
        in_valid = 1'b0;
        chkIdle("after");
        chk("chk_err", chk_err, expChk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) refValid[a] = 1'b0;

        vecs[0] = '{4, 0, 32'h41_82_C3_04, 8'h04, 1'b0};
        vecs[1] = '{3, 2, 32'hA5_5A_3C_00, 8'hC4, 1'b1};
        vecs[2] = '{2, 0, 32'h12_34_00_00, 8'h26, 1'b0};
        vecs[3] = '{2, 1, 32'h12_34_00_00, 8'h27, 1'b1};

        // Reset state, then reset release alone must not start a load.
        step();
        chkIdle("rst");
        chk("rst_chkerr", chk_err, 0);
        reset = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        chkIdle("rel");
        in_valid = 1'b0;

        foreach (vecs[v]) begin
            dataQ.delete();
            for (int i = 0; i < vecs[v].len; i++)
                dataQ.push_back(vecs[v].bytes[31 - 8*i -: 8]);
            runLoad(vecs[v].len, vecs[v].gap, vecs[v].cs);
            for (int i = 0; i < vecs[v].len; i++) begin
                Read_Address = i[7:0];
                #1;
                chk("vec_rd", Instruction, vecs[v].bytes[31 - 8*i -: 8]);
            end
            chk("vec_chkerr", chk_err, (CS_EN != 0) && vecs[v].expErr);
            idleNoise(2);
        end

        // Mismatch flag persists through idle cycles.
        for (int i = 0; i < 5; i++) step();
        chk("sticky", chk_err, CS_EN);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 40);
            dataQ.delete();
            for (int i = 0; i < n; i++) dataQ.push_back(8'($urandom));
            runLoad(n, -1, 8'($urandom));
            idleNoise(3);
        end
        memCheck();

        // Full-depth load: length 0 means 256 bytes.
        dataQ.delete();
        for (int i = 0; i < 256; i++) dataQ.push_back(8'($urandom));
        runLoad(256, 0, 8'($urandom));
        Read_Address = 8'hFF;
        #1;
        chk("full_last", Instruction, dataQ[255]);
        Read_Address = 8'h00;
        #1;
        chk("full_first", Instruction, dataQ[0]);

        // Reset in the middle of a 5-byte load.
        dataQ.delete();
        for (int i = 0; i < 5; i++) dataQ.push_back(8'($urandom));
        load_len   = 8'd5;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = dataQ[i];
            step();
            refMem[i] = dataQ[i];
        end
        in_data = dataQ[2];
        #2;
        chk("mid_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        chkIdle("midrst");
        chk("midrst_chkerr", chk_err, 0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            step();
            chkIdle("postrst");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Read_Address = i[7:0];
            #1;
            chk("midrst_rd", Instruction, dataQ[i]);
        end
        memCheck();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 8, instruction address width; memory depth = 2**ADDR_W.
REQ-002 Parameter: DATA_W, 8, instruction width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_start  input  1  one-cycle request to begin a program load.
REQ-006 load_len  input  ADDR_W  number of instruction bytes to load; 0 means 2**ADDR_W; sampled with load_start.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  DATA_W  byte-stream data.
REQ-009 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high on a rising edge.
REQ-010 Read_Address  input  ADDR_W  CPU fetch address (PC).
REQ-011 Instruction  output  DATA_W  CPU fetch data.
REQ-012 cpu_hold  output  1  high while the CPU must be held (PC frozen/reset).
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 load_done  output  1  one-cycle pulse on load completion.
REQ-015 chk_err  output  1  checksum mismatch flag (see Configuration).

Function
REQ-016 FSM states: IDLE, LOAD, CHECK (checksum build only), DONE.
REQ-017 IDLE: load_start=1 -> LOAD next cycle; write pointer cleared to 0; remaining count loaded from load_len (0 -> 2**ADDR_W); checksum accumulator cleared to 0; chk_err cleared.
REQ-018 load_start outside IDLE: ignored, no effect on pointer, count or state.
REQ-019 in_ready = 1 exactly in LOAD and CHECK; 0 in IDLE and DONE; in_valid outside those states is ignored.
REQ-020 LOAD transfer: mem[ptr] <= in_data, ptr <= ptr+1 (wraps modulo 2**ADDR_W), count <= count-1, accumulator <= accumulator XOR in_data.
REQ-021 LOAD exit: on the transfer with count=1 -> CHECK if checksum built, else DONE; in_valid low stalls indefinitely with no state change.
REQ-022 CHECK: next transfer is the checksum byte, not written to memory; chk_err <= (in_data != accumulator); -> DONE.
REQ-023 DONE: lasts exactly one cycle, load_done=1, then -> IDLE.
REQ-024 busy = 1 in LOAD, CHECK, DONE; cpu_hold = busy.
REQ-025 Instruction = mem[Read_Address], combinational, zero-latency, in all states.
REQ-026 Write and read of the same address in one cycle: Instruction shows old contents until the edge, new contents after.
REQ-027 chk_err is sticky from CHECK until the next accepted load_start.

Reset
REQ-028 reset low forces immediately: state IDLE, ptr 0, count 0, accumulator 0, in_ready 0, busy 0, cpu_hold 0, load_done 0, chk_err 0.
REQ-029 Memory contents are not cleared by reset; a reset mid-load leaves already-written bytes in place and abandons the rest.
REQ-030 Release of reset requires a new load_start to begin any load.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: CHECK state, accumulator and chk_err logic are built per REQ-021/022/027.
REQ-032 Macro undefined: no CHECK state or accumulator; LOAD exits directly to DONE; chk_err tied 0.

Structure
REQ-033 Package imem_loader_pkg holds the FSM state enumeration and default ADDR_W/DATA_W constants.
REQ-034 One sub-module imem_ram: 2**ADDR_W x DATA_W, synchronous write port, asynchronous read port; instantiated once.

Verification
REQ-035 load_len=4, bytes 8'h41,8'h82,8'hC3,8'h04 streamed back-to-back -> in_ready high 4 cycles, load_done pulse, Read_Address 0..3 returns those bytes, cpu_hold low after.
REQ-036 load_len=3 with in_valid gaps of 2 cycles between bytes -> no transfers during gaps, busy held, same stored data, load_done after third byte.
REQ-037 load_len=0 -> exactly 256 bytes accepted, ptr wraps to 0, address 8'hFF holds last byte.
REQ-038 reset pulsed low after 2 of 5 bytes -> busy/cpu_hold drop at once, addresses 0,1 hold loaded bytes, further in_valid ignored.
REQ-039 With IMEM_LOADER_CHECKSUM_EN, bytes 8'h12,8'h34 then checksum 8'h26 -> chk_err 0; checksum 8'h27 -> chk_err 1 until next load_start.
REQ-040 load_start asserted during LOAD -> ignored; pointer and count continue unchanged.
